// File: rtl/adc_pkg.sv
// Shared types, default sizes and the next-channel search for the SAR ADC sequencer.
package adc_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, TRIAL, DONE} sar_state_t;

  localparam int ADC_WIDTH    = 12;
  localparam int ADC_CHANNELS = 3;
  localparam int MAX_CH       = 4;

  // {found, index} of the lowest set bit of mask at or above position from.
  function automatic logic [2:0] first_set(input logic [MAX_CH-1:0] mask, input int from);
    first_set = '0;
    for (int i = MAX_CH-1; i >= 0; i--)
      if (mask[i] && i >= from) first_set = {1'b1, 2'(i)};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/sar_adc_sequencer.sv
// SAR ADC controller: sweeps enabled mux channels, binary-searches each input
// against the R-2R DAC using a synchronized comparator, and holds per-channel results.
module sar_adc_sequencer
  import adc_pkg::*;
#(
  parameter int WIDTH         = ADC_WIDTH,
  parameter int CHANNELS      = ADC_CHANNELS,
  parameter int TRACK_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_override_n,
  input  logic                      start_i,
  input  logic                      continuous_i,
  input  logic [CHANNELS-1:0]       chan_mask_i,
  input  logic                      comp_i,
  output logic [WIDTH-1:0]          dac_code_o,
  output logic [1:0]                chan_sel_o,
  output logic [CHANNELS*WIDTH-1:0] sample_o,
  output logic                      valid_o,
  output logic [1:0]                valid_chan_o,
  output logic                      busy_o
);
  localparam int MAXC = (TRACK_CYCLES > SETTLE_CYCLES) ? TRACK_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_t                      state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [BW-1:0]                   bit_q, bit_d;
  logic [WIDTH-1:0]                code_q, code_d;
  logic [1:0]                      chan_q, chan_d;
  logic [1:0]                      vchan_q, vchan_d;
  logic [CHANNELS-1:0]             mask_q, mask_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  sample_q;
  logic                            wr;
  logic                            comp_s;
  logic [WIDTH-1:0]                bit_oh;
  logic [2:0]                      fs_nxt, fs_in;

  sync_2ff u_comp_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_override_n),
    .d_i    (comp_i),
    .q_o    (comp_s)
  );

  assign bit_oh = {{(WIDTH-1){1'b0}}, 1'b1} << bit_q;
  assign fs_nxt = first_set(MAX_CH'(mask_q), int'(chan_q) + 1);
  assign fs_in  = first_set(MAX_CH'(chan_mask_i), 0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    code_d  = code_q;
    chan_d  = chan_q;
    vchan_d = vchan_q;
    mask_d  = mask_q;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        code_d = '0;
        if (start_i && (chan_mask_i != '0)) begin
          mask_d  = chan_mask_i;
          chan_d  = fs_in[1:0];
          cnt_d   = CW'(TRACK_CYCLES - 1);
          state_d = TRACK;
        end
      end
      TRACK: begin
        code_d = '0;
        if (cnt_q == '0) begin
          bit_d   = BW'(WIDTH - 1);
          code_d  = {1'b1, {(WIDTH-1){1'b0}}};
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = TRIAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TRIAL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Decide the current bit and, unless this was the LSB, raise the next trial bit.
          code_d = comp_s ? code_q : (code_q & ~bit_oh);
          if (bit_q != '0) begin
            bit_d  = bit_q - 1'b1;
            code_d = code_d | (bit_oh >> 1);
            cnt_d  = CW'(SETTLE_CYCLES - 1);
          end else begin
            wr      = 1'b1;
            vchan_d = chan_q;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        code_d = '0;
        cnt_d  = CW'(TRACK_CYCLES - 1);
        if (fs_nxt[2]) begin
          chan_d  = fs_nxt[1:0];
          state_d = TRACK;
        end else if (continuous_i) begin
          mask_d = chan_mask_i;
          if (chan_mask_i != '0) begin
            chan_d  = fs_in[1:0];
            state_d = TRACK;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      chan_q  <= '0;
      vchan_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      chan_q  <= chan_d;
      vchan_q <= vchan_d;
      mask_q  <= mask_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_res
    always_ff @(posedge clk_i or negedge rst_override_n) begin
      if (!rst_override_n)                sample_q[g] <= '0;
      else if (wr && (chan_q == 2'(g)))   sample_q[g] <= code_d;
    end
  end

  assign dac_code_o   = code_q;
  assign chan_sel_o   = chan_q;
  assign sample_o     = sample_q;
  assign valid_o      = (state_q == DONE);
  assign valid_chan_o = vchan_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Directed bench for sar_adc_sequencer with a behavioural comparator on a 4-input mux.
module tb_sar_adc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont;
  logic [2:0]  mask;
  logic        comp;
  logic [11:0] dac;
  logic [1:0]  csel, vchan;
  logic [35:0] samp;
  logic        valid, busy;
  logic [11:0] vin [4];
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  sar_adc_sequencer dut (
    .clk_i          (clk),
    .rst_override_n (rst_n),
    .start_i        (start),
    .continuous_i   (cont),
    .chan_mask_i    (mask),
    .comp_i         (comp),
    .dac_code_o     (dac),
    .chan_sel_o     (csel),
    .sample_o       (samp),
    .valid_o        (valid),
    .valid_chan_o   (vchan),
    .busy_o         (busy)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) comp <= 1'b0;
    else        comp <= (vin[csel] >= dac);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [2:0] m);
    mask  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; mask = 3'b000;
    foreach (vin[i]) vin[i] = 12'h000;
    tick(); tick();
    chk("rst_dac", 64'(dac), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_samp", 64'(samp), 64'h0);
    chk("rst_csel", 64'(csel), 64'h0);
    rst_n = 1'b1;
    tick();

    // single channel 0
    vin[0] = 12'hA5C;
    pulse_start(3'b001);
    wait_valid(n);
    chk("t1_lat", 64'(n), 64'd112);
    chk("t1_vchan", 64'(vchan), 64'd0);
    chk("t1_samp0", 64'(samp[11:0]), 64'hA5C);
    chk("t1_dac_hold", 64'(dac), 64'hA5C);
    chk("t1_busy_done", 64'(busy), 64'h1);
    tick();
    chk("t1_busy_fall", 64'(busy), 64'h0);
    chk("t1_valid_pulse", 64'(valid), 64'h0);

    // full-scale extremes
    vin[0] = 12'hFFF;
    pulse_start(3'b001);
    wait_valid(n);
    chk("t2_samp_ff", 64'(samp[11:0]), 64'hFFF);
    vin[0] = 12'h000;
    tick();
    pulse_start(3'b001);
    wait_valid(n);
    chk("t2_samp_00", 64'(samp[11:0]), 64'h000);
    tick();
    chk("t2_dac_idle", 64'(dac), 64'h0);

    // two channels, skipping channel 1
    vin[0] = 12'h123; vin[2] = 12'h9AB;
    pulse_start(3'b101);
    wait_valid(n);
    chk("t3_lat0", 64'(n), 64'd112);
    chk("t3_vchan0", 64'(vchan), 64'd0);
    chk("t3_samp0", 64'(samp[11:0]), 64'h123);
    wait_valid(n);
    chk("t3_period", 64'(n), 64'd113);
    chk("t3_vchan2", 64'(vchan), 64'd2);
    chk("t3_samp2", 64'(samp[35:24]), 64'h9AB);
    chk("t3_samp1", 64'(samp[23:12]), 64'h000);
    tick();
    chk("t3_idle", 64'(busy), 64'h0);

    // continuous sweeps on channel 1
    cont = 1'b1; vin[1] = 12'h400;
    pulse_start(3'b010);
    wait_valid(n);
    chk("t4_lat", 64'(n), 64'd112);
    chk("t4_vchan", 64'(vchan), 64'd1);
    chk("t4_samp_a", 64'(samp[23:12]), 64'h400);
    vin[1] = 12'h7FF;
    wait_valid(n);
    chk("t4_period", 64'(n), 64'd113);
    chk("t4_samp_b", 64'(samp[23:12]), 64'h7FF);
    vin[1] = 12'h555;
    for (int i = 0; i < 50; i++) tick();
    cont = 1'b0;
    wait_valid(n);
    chk("t4_last_lat", 64'(n), 64'd63);
    chk("t4_samp_c", 64'(samp[23:12]), 64'h555);
    tick();
    chk("t4_idle", 64'(busy), 64'h0);

    // async reset during TRIAL bit 5
    vin[0] = 12'hA5C;
    pulse_start(3'b001);
    for (int i = 0; i < 66; i++) tick();
    chk("t5_busy_pre", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_dac", 64'(dac), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_samp", 64'(samp), 64'h0);
    chk("t5_csel", 64'(csel), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_quiet_busy", 64'(busy), 64'h0);
    chk("t5_quiet_dac", 64'(dac), 64'h0);

    // zero mask ignored; start while busy ignored
    pulse_start(3'b000);
    chk("t6_mask0", 64'(busy), 64'h0);
    tick();
    chk("t6_mask0_b", 64'(busy), 64'h0);
    vin[0] = 12'h3C3;
    pulse_start(3'b001);
    for (int i = 0; i < 30; i++) tick();
    pulse_start(3'b100);
    wait_valid(n);
    chk("t6_lat", 64'(n), 64'd81);
    chk("t6_vchan", 64'(vchan), 64'd0);
    chk("t6_samp0", 64'(samp[11:0]), 64'h3C3);
    tick();
    chk("t6_idle", 64'(busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
